// File: rtl/mat_pkg.sv
// Shared types for the memory stream reader: FSM state encoding and the
// depth of the small output buffer that decouples memory latency from the
// stream consumer.
package mat_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Entries in the output buffer; the read-issue throttle keeps the sum of
   // buffered and in-flight words at or below this.
   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Bundle of the reader's control, memory-read and output-stream signals.
//
// Handshake semantics (output stream): the reader raises out_valid whenever a
// word is buffered and keeps out_data stable until it is taken. A word moves
// in any cycle where out_valid and out_ready are both high; out_ready may
// change freely and out_valid never depends on it. The control side uses a
// single-cycle start pulse (ignored while busy) and a single-cycle done pulse.
// The memory side is a plain read port whose data appears one cycle after the
// address is presented.
//
// master: the reader block itself. slave: its environment (controller,
// memory and stream consumer).
interface mem_stream_reader_if #(
   parameter int elementsNum = 4,
   parameter int dataWidth   = 4
);
   localparam int AW = $clog2(elementsNum);

   logic                 start;
   logic [AW-1:0]        base_addr;
   logic [AW:0]          len;
   logic                 busy;
   logic                 done;
   logic [AW-1:0]        mem_rdaddr;
   logic [dataWidth-1:0] mem_rddata;
   logic                 out_valid;
   logic [dataWidth-1:0] out_data;
   logic                 out_ready;

   modport master (
      input  start, base_addr, len, mem_rddata, out_ready,
      output busy, done, mem_rdaddr, out_valid, out_data
   );

   modport slave (
      output start, base_addr, len, mem_rddata, out_ready,
      input  busy, done, mem_rdaddr, out_valid, out_data
   );

endinterface

// File: rtl/rd_fifo.sv
// Two-entry output buffer for the stream reader. The producer never pushes
// into a full buffer and the consumer never pops an empty one; both are
// guaranteed by the reader's issue throttle and valid gating.
module rd_fifo
   import mat_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic [W-1:0] data
);

   logic [W-1:0] store_q [FIFO_DEPTH];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;

   // Storage, pointers and occupancy; reset clears contents so the head reads 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            store_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            store_q[wr_ptr_q] <= push_data;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign count = count_q;
   assign data  = store_q[rd_ptr_q];

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: on start, reads len consecutive words (address wraps at the
// top of memory) from a registered-output memory and presents them as a
// valid/ready stream through a two-entry buffer.
module mem_stream_reader
   import mat_pkg::*;
#(
   parameter int elementsNum = 4,
   parameter int dataWidth   = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_stream_reader_if.master bus,
   output state_t              dbg_state
);

   localparam int AW = $clog2(elementsNum);

   state_t         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [AW-1:0]  rdaddr_q;
   logic [AW:0]    rem_q, rem_d;
   logic           pend_q;
   logic           done_q, done_d;
   logic           issue;
   logic           pop;
   logic [1:0]     fifo_count;
   logic [2:0]     occupancy;
   logic [dataWidth-1:0] fifo_data;

   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
      return (a == AW'(elementsNum - 1)) ? '0 : a + 1'b1;
   endfunction

   // A word leaves whenever the consumer accepts a buffered word.
   assign pop       = (fifo_count != 2'd0) && bus.out_ready;

   // Buffer slots that will be taken next cycle, counting the read in flight.
   assign occupancy = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, pend_q};

   // Issue only while words remain and the buffer can absorb the return data.
   assign issue     = !rst && (state_q == READ) && (rem_q != '0)
                      && (occupancy < 3'(FIFO_DEPTH));

   // Next-state, address and burst-count logic.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               addr_d = bus.base_addr;
               rem_d  = bus.len;
               if (bus.len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (issue) begin
               addr_d = next_addr(addr_q);
               rem_d  = rem_q - {{AW{1'b0}}, 1'b1};
               if (rem_q == {{AW{1'b0}}, 1'b1}) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Last word is leaving and nothing is still on its way back.
            if (pop && (fifo_count == 2'd1) && !pend_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, burst bookkeeping, in-flight flag and held read address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         pend_q   <= 1'b0;
         done_q   <= 1'b0;
         rdaddr_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         pend_q  <= issue;
         done_q  <= done_d;
         if (issue) begin
            rdaddr_q <= addr_q;
         end
      end
   end

   // Return data is captured the cycle after its read issued.
   rd_fifo #(
      .W (dataWidth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pend_q),
      .push_data (bus.mem_rddata),
      .pop       (pop),
      .count     (fifo_count),
      .data      (fifo_data)
   );

   assign bus.mem_rdaddr = issue ? addr_q : rdaddr_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.out_valid  = (fifo_count != 2'd0);
   assign bus.out_data   = fifo_data;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Testbench for mem_stream_reader with a 4x4 memory holding A,B,C,D.
// Cycle 0 of every burst is the cycle in which start is driven high.
module tb_mem_stream_reader;
  import mat_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  mem_stream_reader_if #(.elementsNum(4), .dataWidth(4)) bus ();

  mem_stream_reader #(.elementsNum(4), .dataWidth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Registered-output memory model.
  logic [3:0] mem_arr [4];
  always @(posedge clk) bus.mem_rddata <= mem_arr[bus.mem_rdaddr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Compare a transferred word against the head of the expected queue.
  task automatic sb_sample(input string tag);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL %s: unexpected word %0h, required none", tag, bus.out_data);
      end else begin
        check(tag, {28'd0, bus.out_data}, {28'd0, exp_q.pop_front()});
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: inputs applied just after the rising edge, outputs
  // sampled on the falling edge.
  task automatic cycle(input logic s, input logic [1:0] b, input logic [2:0] l,
                       input logic r, input logic rs);
    @(posedge clk);
    #1;
    bus.start     = s;
    bus.base_addr = b;
    bus.len       = l;
    bus.out_ready = r;
    rst           = rs;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] base;
    logic [2:0] len;
    logic [3:0] w [4];
    int         inj;   // cycle of an extra start that must be ignored, -1 none
  } vec_t;

  vec_t vecs [7];

  task automatic set_vec(input int i, input logic [1:0] b, input logic [2:0] l,
                         input logic [3:0] w0, input logic [3:0] w1,
                         input logic [3:0] w2, input logic [3:0] w3, input int inj);
    vecs[i].base = b;
    vecs[i].len  = l;
    vecs[i].w[0] = w0;
    vecs[i].w[1] = w1;
    vecs[i].w[2] = w2;
    vecs[i].w[3] = w3;
    vecs[i].inj  = inj;
  endtask

  initial begin
    int         done_c;
    logic       e_busy, e_done, e_valid;
    logic [1:0] ea;

    mem_arr[0] = 4'hA;
    mem_arr[1] = 4'hB;
    mem_arr[2] = 4'hC;
    mem_arr[3] = 4'hD;

    set_vec(0, 2'd0, 3'd4, 4'hA, 4'hB, 4'hC, 4'hD, -1);
    set_vec(1, 2'd2, 3'd4, 4'hC, 4'hD, 4'hA, 4'hB, -1);
    set_vec(2, 2'd1, 3'd2, 4'hB, 4'hC, 4'h0, 4'h0, -1);
    set_vec(3, 2'd3, 3'd1, 4'hD, 4'h0, 4'h0, 4'h0, -1);
    set_vec(4, 2'd0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, -1);
    set_vec(5, 2'd3, 3'd3, 4'hD, 4'hA, 4'hB, 4'h0, -1);
    set_vec(6, 2'd0, 3'd4, 4'hA, 4'hB, 4'hC, 4'hD, 2);

    // ---- reset state ----
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    check("rst_busy",   bus.busy,       0);
    check("rst_done",   bus.done,       0);
    check("rst_valid",  bus.out_valid,  0);
    check("rst_data",   bus.out_data,   0);
    check("rst_rdaddr", bus.mem_rdaddr, 0);
    check("rst_state",  dbg_state,      IDLE);
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);

    // ---- table-driven bursts with out_ready held high ----
    foreach (vecs[i]) begin
      for (int c = 0; c <= vecs[i].len + 5; c++) begin
        cycle((c == 0) || (c == vecs[i].inj),
              (c == 0) ? vecs[i].base : ~vecs[i].base,
              (c == 0) ? vecs[i].len  : 3'd1,
              1'b1, 1'b0);
        e_busy  = (vecs[i].len != 0) && (c >= 1) && (c <= vecs[i].len + 2);
        e_done  = (vecs[i].len == 0) ? (c == 1) : (c == vecs[i].len + 3);
        e_valid = (vecs[i].len != 0) && (c >= 3) && (c <= vecs[i].len + 2);
        check($sformatf("v%0d_c%0d_busy", i, c),  bus.busy,      e_busy);
        check($sformatf("v%0d_c%0d_done", i, c),  bus.done,      e_done);
        check($sformatf("v%0d_c%0d_valid", i, c), bus.out_valid, e_valid);
        if (e_valid)
          check($sformatf("v%0d_c%0d_data", i, c), bus.out_data, vecs[i].w[c - 3]);
        if ((vecs[i].len != 0) && (c >= 1) && (c <= vecs[i].len)) begin
          ea = vecs[i].base + 2'(c - 1);
          check($sformatf("v%0d_c%0d_rdaddr", i, c), bus.mem_rdaddr, ea);
        end
      end
    end

    // ---- backpressure: out_ready low in cycles 3..6 ----
    exp_q  = {4'hA, 4'hB, 4'hC, 4'hD};
    done_c = -1;
    for (int c = 0; c < 20 && done_c < 0; c++) begin
      cycle(c == 0, 2'd0, 3'd4, !((c >= 3) && (c <= 6)), 1'b0);
      if ((c >= 3) && (c <= 6)) begin
        check($sformatf("bp_c%0d_valid", c), bus.out_valid, 1);
        check($sformatf("bp_c%0d_hold", c),  bus.out_data,  4'hA);
      end
      if (c == 6) check("bp_two_reads_rdaddr", bus.mem_rdaddr, 1);
      sb_sample("bp_word");
      if (bus.done) done_c = c;
    end
    check("bp_done_cycle", done_c, 11);
    check("bp_leftover", exp_q.size(), 0);
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);

    // ---- reset in cycle 4 of a burst, then a fresh burst ----
    for (int c = 0; c <= 5; c++) begin
      cycle(c == 0, 2'd0, 3'd4, 1'b1, c == 4);
      if (c == 5) begin
        check("mrst_busy",   bus.busy,       0);
        check("mrst_valid",  bus.out_valid,  0);
        check("mrst_done",   bus.done,       0);
        check("mrst_rdaddr", bus.mem_rdaddr, 0);
      end
    end
    exp_q  = {4'hB, 4'hC};
    done_c = -1;
    for (int c = 0; c < 15 && done_c < 0; c++) begin
      cycle(c == 0, 2'd1, 3'd2, 1'b1, 1'b0);
      sb_sample("mrst_word");
      if (bus.done) done_c = c;
    end
    check("mrst_done_cycle", done_c, 5);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
      check("mrst_no_stale", bus.out_valid, 0);
    end
    check("mrst_leftover", exp_q.size(), 0);

    // ---- start in the same cycle as done is accepted ----
    exp_q = {4'hD, 4'hC, 4'hD};
    for (int c = 0; c <= 12; c++) begin
      cycle((c == 0) || (c == 4), (c == 0) ? 2'd3 : 2'd2, (c == 0) ? 3'd1 : 3'd2,
            1'b1, 1'b0);
      sb_sample("b2b_word");
      if (c == 4) check("b2b_first_done", bus.done, 1);
      if (c == 5) check("b2b_busy_again", bus.busy, 1);
      if (c == 9) check("b2b_second_done", bus.done, 1);
    end
    check("b2b_leftover", exp_q.size(), 0);

    // ---- final report ----
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
